// File: rtl/enable_paced_tx_pkg.sv
// Shared constants for the enable-paced serial transmitter.
// State encodings, frame width, idle line level and parity helper.
package enable_paced_tx_pkg;

  localparam int DATA_BITS = 8;

  localparam logic IDLE_LEVEL = 1'b1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARM    = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_PARITY = 3'd4;
  localparam logic [2:0] S_STOP   = 3'd5;

  function automatic logic parity_bit(
    input logic [DATA_BITS-1:0] d,
    input logic                 odd
  );
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/enable_paced_tx_edge.sv
// Rising-edge detector turning a bit-period enable level into a tick.
// Ports: clk, reset (async active-low), clock_en in; tick out.
module enable_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic clock_en,
  output logic tick
);

  logic clock_en_d_q;
  logic clock_en_d_d;

  always_comb begin
    clock_en_d_d = clock_en;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clock_en_d_q <= 1'b0;
    end else begin
      clock_en_d_q <= clock_en_d_d;
    end
  end

  assign tick = clock_en & ~clock_en_d_q;

endmodule

// File: rtl/enable_paced_tx.sv
// Serial byte transmitter paced by ticks of an external enable level.
// Ports: clk, reset, clock_en, data_in, send in; ready, tx_out, done out.
import enable_paced_tx_pkg::*;

module enable_paced_tx #(
  parameter logic PARITY_EN  = 1'b0,
  parameter logic PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clock_en,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 send,
  output logic                 ready,
  output logic                 tx_out,
  output logic                 done
);

  logic tick;

  enable_edge_detect u_edge (
    .clk      (clk),
    .reset    (reset),
    .clock_en (clock_en),
    .tick     (tick)
  );

  logic [2:0]           state_q, state_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 tx_q, tx_d;
  logic                 rdy_q, rdy_d;
  logic                 done_q, done_d;
  logic [2:0]           idx_nxt;

  assign idx_nxt = idx_q + 3'd1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    tx_d    = tx_q;
    rdy_d   = rdy_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // a tick coinciding with acceptance is
        // deliberately not consumed here
        if (send) begin
          data_d  = data_in;
          rdy_d   = 1'b0;
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        if (tick) begin
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (tick) begin
          state_d = S_DATA;
          tx_d    = data_q[0];
          idx_d   = 3'd0;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (idx_q != 3'd7) begin
            tx_d  = data_q[idx_nxt];
            idx_d = idx_nxt;
          end else if (PARITY_EN) begin
            state_d = S_PARITY;
            tx_d    = parity_bit(data_q, PARITY_ODD);
          end else begin
            state_d = S_STOP;
            tx_d    = IDLE_LEVEL;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          state_d = S_STOP;
          tx_d    = IDLE_LEVEL;
        end
      end
      S_STOP: begin
        if (tick) begin
          state_d = S_IDLE;
          tx_d    = IDLE_LEVEL;
          rdy_d   = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = IDLE_LEVEL;
        rdy_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= 3'd0;
      data_q  <= '0;
      tx_q    <= IDLE_LEVEL;
      rdy_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      rdy_q   <= rdy_d;
      done_q  <= done_d;
    end
  end

  assign ready  = rdy_q;
  assign tx_out = tx_q;
  assign done   = done_q;

endmodule

// File: tb/tb_enable_paced_tx.sv
// Bench for enable_paced_tx: three parity variants against a frame model.
// Directed pacing scenarios plus randomized sends and enable patterns.
module tb_enable_paced_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clock_en = 1'b0;
  logic [2:0] send = '0;
  logic [7:0] data_in [3];
  logic [2:0] ready;
  logic [2:0] tx_out;
  logic [2:0] done;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    enable_paced_tx #(
      .PARITY_EN  (g != 0),
      .PARITY_ODD (g == 2)
    ) u_dut (
      .clk      (clk),
      .reset    (rst_n),
      .clock_en (clock_en),
      .data_in  (data_in[g]),
      .send     (send[g]),
      .ready    (ready[g]),
      .tx_out   (tx_out[g]),
      .done     (done[g])
    );
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // reference model: a frame is a queue of line levels,
  // one popped per tick, then one more tick to finish
  bit   busy [3];
  bit   q [3][$];
  logic line_m [3];
  bit   done_m [3];
  bit   ce_prev = 1'b0;
  int   dn_dut [3];
  int   dn_m [3];

  initial begin
    for (int i = 0; i < 3; i++) begin
      busy[i] = 0; line_m[i] = 1'b1; done_m[i] = 0;
      dn_dut[i] = 0; dn_m[i] = 0; data_in[i] = '0;
    end
  end

  task automatic model_step();
    bit tk;
    tk = clock_en & ~ce_prev;
    for (int i = 0; i < 3; i++) begin
      done_m[i] = 0;
      if (!rst_n) begin
        busy[i] = 0; q[i].delete(); line_m[i] = 1'b1;
      end else if (!busy[i]) begin
        if (send[i]) begin
          busy[i] = 1;
          q[i].push_back(1'b0);
          for (int b = 0; b < 8; b++)
            q[i].push_back(data_in[i][b]);
          if (i != 0)
            q[i].push_back((^data_in[i]) ^ (i == 2));
          q[i].push_back(1'b1);
        end
      end else if (tk) begin
        if (q[i].size() > 0) begin
          line_m[i] = q[i].pop_front();
        end else begin
          busy[i] = 0; done_m[i] = 1; line_m[i] = 1'b1;
          dn_m[i]++;
        end
      end
    end
    ce_prev = rst_n ? clock_en : 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      model_step();
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("tx%0d", i), tx_out[i], line_m[i]);
        chk($sformatf("rdy%0d", i), ready[i], !busy[i]);
        chk($sformatf("done%0d", i), done[i], done_m[i]);
        if (done[i] === 1'b1) dn_dut[i]++;
      end
    end
  end

  // enable generator: pulse of width ce_w every ce_per clks
  int ce_per = 5;
  int ce_w = 1;
  int ph = 0;
  bit ce_rand = 0;
  bit ce_man = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!ce_man) begin
        if (ph >= ce_per) begin
          ph = 0;
          if (ce_rand) begin
            ce_per = $urandom_range(2, 9);
            ce_w = $urandom_range(1, ce_per - 1);
          end
        end
        clock_en = (ph < ce_w);
        ph++;
      end
    end
  end

  task automatic wait_idle(int budget, string tag);
    int k = 0;
    while ((busy[0] | busy[1] | busy[2]) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, k < budget, 1);
  endtask

  task automatic send_all(logic [7:0] d);
    @(negedge clk);
    for (int i = 0; i < 3; i++) data_in[i] = d;
    send = 3'b111;
    @(negedge clk);
    send = '0;
  endtask

  int base [3];
  int cnt [3];
  int k;

  initial begin
    repeat (4) @(negedge clk);
    chk("rst_tx", tx_out, 3'b111);
    chk("rst_rdy", ready, 3'b111);
    chk("rst_done", done, 3'b000);
    rst_n = 1'b1;

    // slow pacing, 0xA5
    ce_per = 100; ce_w = 1;
    for (int i = 0; i < 3; i++) base[i] = dn_dut[i];
    send_all(8'hA5);
    wait_idle(1500, "a5_idle");
    for (int i = 0; i < 3; i++)
      chk($sformatf("a5_dn%0d", i), dn_dut[i] - base[i], 1);

    // send coincident with a tick
    ce_per = 10;
    ce_man = 1;
    @(negedge clk);
    clock_en = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) data_in[i] = 8'h81;
    clock_en = 1'b1; send = 3'b111;
    @(negedge clk);
    clock_en = 1'b0; send = '0;
    repeat (3) @(negedge clk);
    chk("coinc_tx", tx_out, 3'b111);
    chk("coinc_rdy", ready, 3'b000);
    clock_en = 1'b1;
    @(negedge clk);
    clock_en = 1'b0;
    chk("coinc_start", tx_out, 3'b000);
    ce_man = 0;
    wait_idle(300, "coinc_idle");

    // enable held high, sends while busy
    send_all(8'h5A);
    repeat (35) @(negedge clk);
    ce_man = 1;
    clock_en = 1'b1;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      send = 3'($urandom);
      for (int i = 0; i < 3; i++) data_in[i] = 8'($urandom);
    end
    send = '0;
    clock_en = 1'b0;
    ce_man = 0;
    wait_idle(300, "hold_idle");

    // back-to-back frames
    ce_per = 6;
    for (int i = 0; i < 3; i++) begin
      cnt[i] = 0; base[i] = dn_dut[i];
    end
    k = 0;
    while (k < 600 &&
           (cnt[0] + cnt[1] + cnt[2] < 6 ||
            (busy[0] | busy[1] | busy[2]))) begin
      @(negedge clk);
      k++;
      for (int i = 0; i < 3; i++) begin
        send[i] = !busy[i] && cnt[i] < 2;
        if (send[i]) begin
          data_in[i] = (cnt[i] == 0) ? 8'h3C : 8'hC3;
          cnt[i]++;
        end
      end
    end
    send = '0;
    chk("b2b_bound", k < 600, 1);
    for (int i = 0; i < 3; i++)
      chk($sformatf("b2b_dn%0d", i), dn_dut[i] - base[i], 2);

    // abort during data bit 4
    ce_per = 8;
    send_all(8'($urandom));
    k = 0;
    while (!(busy[0] && q[0].size() == 4) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("abort_wait", k < 200, 1);
    for (int i = 0; i < 3; i++) base[i] = dn_dut[i];
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_tx", tx_out, 3'b111);
    chk("abort_rdy", ready, 3'b111);
    chk("abort_done", done, 3'b000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++)
      chk($sformatf("abort_nodn%0d", i), dn_dut[i], base[i]);
    send_all(8'h96);
    wait_idle(300, "abort_idle");
    for (int i = 0; i < 3; i++)
      chk($sformatf("abort_dn%0d", i), dn_dut[i] - base[i], 1);

    // random traffic and pacing
    ce_rand = 1;
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        send[i] = ($urandom_range(0, 15) == 0);
        data_in[i] = 8'($urandom);
      end
    end
    send = '0;
    ce_rand = 0; ce_per = 5; ce_w = 1;
    wait_idle(300, "rand_idle");
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      chk($sformatf("dn_total%0d", i), dn_dut[i], dn_m[i]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
